mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
- Uses a fixed-latency memory protocol and serialises requests with a small FSM.
- Returns a one-cycle ready pulse to the winning requester, which stalls the core until then.
- Sits between the core's instruction/memory interfaces and the shared memory macro, and replaces separate instruction and data memories.

Parameters:
- MEM_LATENCY, 1, cycles from the memory issue cycle to valid mem_rdata; legal range 1..15.
- ADDR_W, 32, address and data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch address (pc).
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  ADDR_W  fetched instruction; valid while if_ready=1, held afterwards.
- if_err  out  1  misaligned fetch flag; valid with if_ready.
- d_req  in  1  data request; held with all d_* fields stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  ADDR_W  store data.
- d_ready  out  1  one-cycle completion pulse for data.
- d_rdata  out  ADDR_W  load data; updated on loads only.
- d_err  out  1  misaligned data flag; valid with d_ready.
- mem_en  out  1  memory access strobe; high for exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  ADDR_W  memory write data.
- mem_rdata  in  ADDR_W  memory read data; valid MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset: sampled at the clock edge while reset=0. Effects:
  - state returns to IDLE and the latency counter clears;
  - all outputs and the rdata/err registers go to 0;
  - an in-flight access is abandoned with no ready pulse and no further mem_en;
  - a write already strobed is not undone.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: samples requests.
  - If d_req=1, data wins. Fixed data priority: the data access belongs to the older instruction.
  - Otherwise if if_req=1, fetch wins.
  - The owner and the address/wdata/we are latched.
  - Aligned request (addr[1:0]=00) -> ISSUE; misaligned -> ERR.
  - No request -> stay in IDLE.
- ISSUE: one cycle.
  - mem_en=1, mem_addr = latched address.
  - mem_we = latched we for data, 0 for fetch.
  - mem_wdata = latched wdata, else 0.
  - Counter loads MEM_LATENCY; go to WAIT.
- WAIT: counter decrements each cycle.
  - When the counter reaches 1, mem_rdata is captured into the owner's rdata register, but only for fetch or load. Stores leave d_rdata unchanged.
  - Then go to DONE. WAIT lasts exactly MEM_LATENCY cycles.
- DONE: owner's ready=1 and err=0 for one cycle; then go to IDLE unconditionally.
  - The completed requester's req, still high in this cycle, is ignored.
- ERR: owner's ready=1 and err=1 for one cycle; no memory access; then go to IDLE.
- Latency, with the request first sampled at cycle N:
  - mem_en at N+1;
  - ready at N+MEM_LATENCY+2;
  - next IDLE sample at N+MEM_LATENCY+3.
  - Misaligned request: ready at N+1.
- Outside their pulse, ready and err are 0. if_rdata and d_rdata hold their last captured value.
- mem_addr, mem_wdata and mem_we are 0 whenever mem_en=0.
- Requests that arrive while busy wait; none are dropped.
- A req deasserted before ready is a protocol violation. The transaction still completes and still pulses ready.
- Counter width is 4 bits; there is no wrap because the counter is loaded fresh for each access.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERR=4, 3 bits);
  - the owner encoding (OWN_IF=0, OWN_D=1);
  - the alignment-mask constant.
- One sub-module, mem_latency_timer: a load/decrement counter with a last-cycle flag. The FSM stays in the top module.

Test Plan:
1. Fetch only, MEM_LATENCY=1, if_req at cycle 0, if_addr=0x10, memory returns 0x00500093 -> mem_en=1 and mem_addr=0x10 at cycle 1; if_ready=1 and if_rdata=0x00500093 at cycle 3; d_ready stays 0.
2. Simultaneous if_req (0x20) and d_req load (0x100) at cycle 0, MEM_LATENCY=1 -> mem_addr=0x100 at cycle 1 and d_ready at cycle 3; fetch mem_en with 0x20 at cycle 5 and if_ready at cycle 7.
3. Store d_addr=0x200, d_wdata=0xDEADBEEF -> at cycle 1 mem_en=mem_we=1 and mem_wdata=0xDEADBEEF for exactly one cycle; d_ready at cycle 3; d_rdata equals its prior value.
4. Load d_addr=0x102 -> no mem_en at any cycle; d_ready=d_err=1 at cycle 1; next request is accepted at cycle 2.
5. MEM_LATENCY=4, reset driven to 0 at cycle 3 (during WAIT) -> all outputs 0 from cycle 4 and no ready pulse; after reset=1, a new fetch completes with ready at start+6.
6. MEM_LATENCY=3, if_req held continuously across two back-to-back fetches -> if_ready at cycles 5 and 11; mem_en at cycles 1 and 7; never two accesses in flight.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Imported by the arbiter top and its latency timer.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         CNT_W      = 4;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Load/decrement latency counter; flags the final wait cycle.
// Reloaded for every access, so it never wraps.
module mem_latency_timer
    import mem_arb_pkg::*;
#(
    parameter int LOAD_VAL = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-port memory.
// Data has fixed priority; every access is serialised through the FSM.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [ADDR_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata
);

    state_t            state;
    owner_t            owner;
    logic              we_q;
    logic              timer_last;
    logic [ADDR_W-1:0] req_addr;
    logic              misaligned;

    // Data access belongs to the older instruction, so it always wins.
    assign req_addr   = d_req ? d_addr : if_addr;
    assign misaligned = |(req_addr[1:0] & ALIGN_MASK);

    mem_latency_timer #(
        .LOAD_VAL(MEM_LATENCY)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .load (state == ISSUE),
        .last (timer_last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            we_q      <= 1'b0;
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        owner <= d_req ? OWN_D : OWN_IF;
                        we_q  <= d_req & d_we;
                        if (misaligned) begin
                            state <= ERR;
                            if (d_req) begin
                                d_ready <= 1'b1;
                                d_err   <= 1'b1;
                            end else begin
                                if_ready <= 1'b1;
                                if_err   <= 1'b1;
                            end
                        end else begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= d_req & d_we;
                            mem_addr  <= req_addr;
                            mem_wdata <= d_req ? d_wdata : '0;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (timer_last) begin
                        state <= DONE;
                        if (owner == OWN_D) begin
                            d_ready <= 1'b1;
                            if (!we_q) d_rdata <= mem_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences, random traffic.
// Expected cycles and data come from a transaction-level model and a reference memory.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_d = '0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .MEM_LATENCY(LAT),
        .ADDR_W     (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory macro: fixed read latency, garbage on the bus when no read is due.
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] rd_pipe [LAT];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge clock) begin
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : $urandom;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always @(posedge clock) begin
        if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    end

    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " if_ready"}, 32'(if_ready), 0);
        chk({tag, " d_ready"}, 32'(d_ready), 0);
        chk({tag, " if_err"}, 32'(if_err), 0);
        chk({tag, " d_err"}, 32'(d_err), 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " if_rdata"}, if_rdata, 0);
        chk({tag, " d_rdata"}, d_rdata, 0);
    endtask

    // Transaction-level timing: data first, fetch at the following idle slot.
    task automatic model(input bit ifr, input logic [31:0] ia, input bit dr,
                         input logic [31:0] da, output int exp_d,
                         output int exp_if, output bit derr, output bit iferr);
        int t = 0;
        derr  = dr && (da[1:0] != 2'b00);
        iferr = ifr && (ia[1:0] != 2'b00);
        exp_d  = 0;
        exp_if = 0;
        if (dr) begin
            exp_d = derr ? 1 : LAT + 2;
            t = exp_d + 1;
        end
        if (ifr) exp_if = t + (iferr ? 1 : LAT + 2);
    endtask

    // Called at a negedge while the arbiter is idle; cycle 0 is the sample slot.
    task automatic run_txn(input string tag, input bit ifr,
                           input logic [31:0] ia, input bit dr, input bit dwe,
                           input logic [31:0] da, input logic [31:0] dwd,
                           input int exp_d, input int exp_if,
                           input bit exp_derr, input bit exp_iferr);
        int last = (exp_d > exp_if) ? exp_d : exp_if;
        int en_d = (dr && !exp_derr) ? exp_d - LAT - 1 : -1;
        int en_if = (ifr && !exp_iferr) ? exp_if - LAT - 1 : -1;
        logic [31:0] exp_drd = last_d;
        logic [31:0] exp_ird = last_if;
        if (dr && !exp_derr && !dwe) exp_drd = ref_word(da);
        if (dr && !exp_derr && dwe) ref_mem[da] = dwd;
        if (ifr && !exp_iferr) exp_ird = ref_word(ia);
        if_req  = ifr;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clock);
            chk({tag, " if_ready"}, 32'(if_ready), 32'(k == exp_if));
            chk({tag, " d_ready"}, 32'(d_ready), 32'(k == exp_d));
            chk({tag, " if_err"}, 32'(if_err), 32'(k == exp_if && exp_iferr));
            chk({tag, " d_err"}, 32'(d_err), 32'(k == exp_d && exp_derr));
            chk({tag, " mem_en"}, 32'(mem_en), 32'(k == en_d || k == en_if));
            if (k == en_d) begin
                chk({tag, " d mem_addr"}, mem_addr, da);
                chk({tag, " d mem_we"}, 32'(mem_we), 32'(dwe));
                if (dwe) chk({tag, " d mem_wdata"}, mem_wdata, dwd);
            end else if (k == en_if) begin
                chk({tag, " if mem_addr"}, mem_addr, ia);
                chk({tag, " if mem_we"}, 32'(mem_we), 0);
                chk({tag, " if mem_wdata"}, mem_wdata, 0);
            end else begin
                chk({tag, " idle mem_addr"}, mem_addr, 0);
                chk({tag, " idle mem_we"}, 32'(mem_we), 0);
            end
            if (k == exp_d || k == last + 1)
                chk({tag, " d_rdata"}, d_rdata, exp_drd);
            if (k == exp_if || k == last + 1)
                chk({tag, " if_rdata"}, if_rdata, exp_ird);
            if (d_ready) d_req = 1'b0;
            if (if_ready) if_req = 1'b0;
        end
        if_req  = 1'b0;
        d_req   = 1'b0;
        last_d  = exp_drd;
        last_if = exp_ird;
    endtask

    typedef struct {
        bit          ifr;
        logic [31:0] ia;
        bit          dr;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        int          exp_d;
        int          exp_if;
        bit          exp_derr;
        bit          exp_iferr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1, 32'h10, 0, 0, 32'h0, 32'h0, 0, LAT + 2, 0, 0};
        vecs[1] = '{1, 32'h20, 1, 0, 32'h100, 32'h0, LAT + 2, 2 * LAT + 5, 0, 0};
        vecs[2] = '{0, 32'h0, 1, 1, 32'h200, 32'hDEADBEEF, LAT + 2, 0, 0, 0};
        vecs[3] = '{0, 32'h0, 1, 0, 32'h102, 32'h0, 1, 0, 1, 0};
        vecs[4] = '{1, 32'h13, 0, 0, 32'h0, 32'h0, 0, 1, 0, 1};
        vecs[5] = '{0, 32'h0, 1, 0, 32'h200, 32'h0, LAT + 2, 0, 0, 0};
        vecs[6] = '{1, 32'h200, 1, 1, 32'h201, 32'h55AA55AA, 1, LAT + 4, 1, 0};
        vecs[7] = '{1, 32'h300, 1, 1, 32'h300, 32'h12345678, LAT + 2, 2 * LAT + 5, 0, 0};
        vecs[8] = '{1, 32'h31, 1, 0, 32'h104, 32'h0, LAT + 2, LAT + 4, 0, 1};

        mem_arr[32'h10] = 32'h00500093;
        ref_mem[32'h10] = 32'h00500093;

        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].ifr, vecs[i].ia,
                    vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd,
                    vecs[i].exp_d, vecs[i].exp_if, vecs[i].exp_derr,
                    vecs[i].exp_iferr);
        end

        // Fetch held high across two back-to-back accesses.
        if_req  = 1'b1;
        if_addr = 32'h40;
        for (int k = 1; k <= 2 * LAT + 6; k++) begin
            @(negedge clock);
            chk("b2b if_ready", 32'(if_ready),
                32'(k == LAT + 2 || k == 2 * LAT + 5));
            chk("b2b mem_en", 32'(mem_en), 32'(k == 1 || k == LAT + 4));
            if (k == 2 * LAT + 5) begin
                chk("b2b if_rdata", if_rdata, ref_word(32'h40));
                if_req = 1'b0;
            end
        end
        last_if = ref_word(32'h40);

        // Reset in the middle of WAIT abandons the fetch silently.
        if_req  = 1'b1;
        if_addr = 32'h44;
        for (int k = 1; k <= 3; k++) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_zero("midreset k4");
        if_req = 1'b0;
        @(negedge clock);
        chk_zero("midreset k5");
        reset   = 1'b1;
        last_if = '0;
        last_d  = '0;
        run_txn("post-reset", 1, 32'h48, 0, 0, 32'h0, 32'h0, 0, LAT + 2, 0, 0);

        for (int i = 0; i < 40; i++) begin
            bit          ifr = 1'($urandom_range(0, 1));
            bit          dr = 1'($urandom_range(0, 1));
            bit          dwe = 1'($urandom_range(0, 1));
            logic [31:0] ia = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
            logic [31:0] da = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
            logic [31:0] dwd = $urandom;
            int exp_d, exp_if;
            bit derr, iferr;
            if (!ifr && !dr) ifr = 1'b1;
            if ($urandom_range(0, 4) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) da[1:0] = 2'($urandom_range(1, 3));
            model(ifr, ia, dr, da, exp_d, exp_if, derr, iferr);
            run_txn($sformatf("rand%0d", i), ifr, ia, dr, dwe, da, dwd,
                    exp_d, exp_if, derr, iferr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
